// File: rtl/ct_mmu_jtlb_tag_array_cfg_pkg.sv
// Shared MMU JTLB tag array definitions.
// Default geometry and sequencer state encoding.
package ct_mmu_jtlb_tag_array_cfg_pkg;

  localparam int JTLB_WAYS  = 4;
  localparam int JTLB_TAG_W = 48;
  localparam int JTLB_DEPTH = 256;
  localparam int JTLB_IDX_W = $clog2(JTLB_DEPTH);
  localparam int JTLB_ROW_W = JTLB_WAYS * JTLB_TAG_W + JTLB_WAYS;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } jtlb_tag_state_e;

endpackage

// File: rtl/ct_mmu_spsram_cfg.sv
// Behavioural single-port SRAM, active-low controls.
// One-cycle read latency; Q is not refreshed by writes.
module ct_mmu_spsram_cfg #(
  parameter int WIDTH  = 196,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              cen,
  input  logic              gwen,
  input  logic [WIDTH-1:0]  wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!gwen)
        mem[addr] <= (mem[addr] & wen) | (din & ~wen);
      else
        q <= mem[addr];
    end
  end

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate.
// Enable is captured while the clock is low.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic en_bf;
  logic en_lat;

  assign en_bf = (global_en & (module_en | local_en)) | external_en;

  always_latch begin
    if (!clk_in)
      en_lat = en_bf | pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/ct_mmu_jtlb_tag_array_cfg.sv
// Parametrised JTLB tag array: masked SRAM access,
// hardware invalidate-all sequencer and held read data.
module ct_mmu_jtlb_tag_array_cfg
  import ct_mmu_jtlb_tag_array_cfg_pkg::*;
#(
  parameter int WAYS  = JTLB_WAYS,
  parameter int TAG_W = JTLB_TAG_W,
  parameter int DEPTH = JTLB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int ROW_W = WAYS * TAG_W + WAYS
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             cp0_mmu_icg_en,
  input  logic             pad_yy_icg_scan_en,
  input  logic             jtlb_tag_cen,
  input  logic [IDX_W-1:0] jtlb_tag_idx,
  input  logic [WAYS:0]    jtlb_tag_wen,
  input  logic [ROW_W-1:0] jtlb_tag_din,
  input  logic             jtlb_tag_inv_all,
  output logic             jtlb_tag_ready,
  output logic [ROW_W-1:0] jtlb_tag_dout,
  output logic             jtlb_tag_dout_vld,
  output logic             jtlb_tag_init_busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  jtlb_tag_state_e  state;
  jtlb_tag_state_e  state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;
  logic [ROW_W-1:0] hold;
  logic             dout_vld;

  logic             init_st;
  logic             acc;
  logic             is_wr;
  logic [ROW_W-1:0] wr_mask;

  logic             sram_clk;
  logic             sram_cen_n;
  logic             sram_gwen_n;
  logic [ROW_W-1:0] sram_wen_n;
  logic [IDX_W-1:0] sram_addr;
  logic [ROW_W-1:0] sram_din;
  logic [ROW_W-1:0] sram_q;

  assign init_st = (state == ST_INIT);
  assign acc     = jtlb_tag_cen & ~init_st;
  assign is_wr   = |jtlb_tag_wen;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_INIT: begin
        if (jtlb_tag_inv_all) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_IDX) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (jtlb_tag_inv_all) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state    <= ST_INIT;
      cnt      <= '0;
      dout_vld <= 1'b0;
      hold     <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dout_vld <= acc & ~is_wr;
      if (dout_vld)
        hold <= sram_q;
    end
  end

  // Way bits widen to a whole tag; the top bit covers the FIFO field.
  always_comb begin
    wr_mask = '0;
    for (int w = 0; w < WAYS; w++)
      wr_mask[w*TAG_W +: TAG_W] = {TAG_W{jtlb_tag_wen[w]}};
    wr_mask[WAYS*TAG_W +: WAYS] = {WAYS{jtlb_tag_wen[WAYS]}};
  end

  always_comb begin
    sram_cen_n  = 1'b1;
    sram_gwen_n = 1'b1;
    sram_wen_n  = '1;
    sram_addr   = jtlb_tag_idx;
    sram_din    = jtlb_tag_din;
    unique case (1'b1)
      init_st: begin
        sram_cen_n  = 1'b0;
        sram_gwen_n = 1'b0;
        sram_wen_n  = '0;
        sram_addr   = cnt;
        sram_din    = '0;
      end
      acc: begin
        sram_cen_n  = 1'b0;
        sram_gwen_n = ~is_wr;
        sram_wen_n  = ~wr_mask;
      end
      default: begin
        sram_cen_n = 1'b1;
      end
    endcase
  end

  gated_clk_cell x_jtlb_tag_gateclk (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (cp0_mmu_icg_en),
    .local_en           (acc | init_st),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (sram_clk)
  );

  ct_mmu_spsram_cfg #(
    .WIDTH  (ROW_W),
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) x_jtlb_tag_sram (
    .clk  (sram_clk),
    .cen  (sram_cen_n),
    .gwen (sram_gwen_n),
    .wen  (sram_wen_n),
    .addr (sram_addr),
    .din  (sram_din),
    .q    (sram_q)
  );

  assign jtlb_tag_ready     = ~init_st;
  assign jtlb_tag_init_busy = init_st;
  assign jtlb_tag_dout_vld  = dout_vld;
  assign jtlb_tag_dout      = dout_vld ? sram_q : hold;

endmodule
